dcache_wb_responder: RTL and testbench
======================================

Name: dcache_wb_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Responds to the pipelined CPU's MEM-stage load/store requests and replaces the single-cycle DataMemory on the CPU side.
- Issues block-granular read/write transactions to a multi-cycle backing memory over a valid/ready request channel and a response-valid channel.
- Provides the hit/miss signals the CPU needs to stall its pipeline, plus hit/miss statistics counters.

Parameters:
- NUM_SETS, 16, number of cache lines; power of two; index width = log2(NUM_SETS).
- WORDS_PER_LINE, 4, 32-bit words per line; power of two; line = 128 bits at default.

Ports:
- reset  input  1  synchronous, active-high.
- clk  input  1  single clock; all state updates on posedge.
- is_input_valid  input  1  CPU request present this cycle.
- addr  input  32  byte address; bits [1:0] ignored.
- mem_rw  input  1  0 = load, 1 = store.
- din  input  32  store data.
- is_ready  output  1  cache can accept a request this cycle.
- is_output_valid  output  1  one-cycle pulse: load data valid or store completed.
- dout  output  32  load data; valid only with is_output_valid.
- is_hit  output  1  with is_output_valid: 1 if the access hit on first lookup.
- mem_req_valid  output  1  backing-memory request.
- mem_req_ready  input  1  backing memory accepts request.
- mem_req_write  output  1  1 = writeback, 0 = fill.
- mem_req_addr  output  32  line-aligned byte address.
- mem_wdata  output  32*WORDS_PER_LINE  victim line data.
- mem_resp_valid  input  1  fill data valid, or write acknowledged.
- mem_rdata  input  32*WORDS_PER_LINE  fill line.
- hit_count  output  32  completed requests that hit.
- miss_count  output  32  completed requests that missed.

Behaviour:
- Address split:
  - offset = addr[log2(W)+1:2]
  - index = next log2(NUM_SETS) bits
  - tag = remaining upper bits
  - Word k of a line occupies bits [32k+31:32k].
- Reset:
  - state IDLE; all valid and dirty bits 0; counters 0.
  - is_ready=1, is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0.
  - Reset mid-miss aborts the transaction; the backing memory is reset on the same edge.
- FSM states: IDLE, COMPARE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT.
- IDLE:
  - is_ready=1.
  - is_input_valid=1 latches addr/mem_rw/din and clears an internal miss flag, then goes to COMPARE.
  - is_input_valid is ignored in every other state (is_ready=0).
- COMPARE:
  - Hit = valid[index] && tag match.
  - Hit, load: dout = word at offset; is_output_valid=1; is_hit = !miss flag.
  - Hit, store: write din into that word; set dirty; is_output_valid=1.
  - On either hit, increment hit_count if the miss flag is 0, else miss_count; then go to IDLE.
  - Hit latency: accept at edge N, is_output_valid high during cycle N+1.
- Miss:
  - Set the miss flag.
  - Victim valid && dirty: go to WB_REQ. Otherwise go to AL_REQ. Invalid lines are never written back.
- WB_REQ:
  - mem_req_valid=1, mem_req_write=1.
  - mem_req_addr = {victim tag, index, 0}; mem_wdata = victim line.
  - Hold until mem_req_ready, then go to WB_WAIT.
- WB_WAIT: wait for mem_resp_valid, then go to AL_REQ.
- AL_REQ:
  - mem_req_valid=1, mem_req_write=0, mem_req_addr = {request tag, index, 0}.
  - Hold until mem_req_ready, then go to AL_WAIT.
- AL_WAIT:
  - On mem_resp_valid: line = mem_rdata, valid=1, dirty=0, tag = request tag.
  - Go to COMPARE, which now hits; a store then merges and sets dirty.
- Request stability: mem_req_* remain stable while mem_req_valid=1 and !mem_req_ready.
- Spurious responses: mem_resp_valid outside WB_WAIT/AL_WAIT is ignored.
- Counters wrap at 2^32.
- Exactly one of hit_count or miss_count increments per is_output_valid pulse.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams).
  - Derived widths: OFFSET_W, INDEX_W, TAG_W, LINE_W.
  - mem_rw encodings.
- One natural sub-module: dcache_line_array. It holds the tag/valid/dirty/data storage, with one combinational read port and one synchronous write port (full-line fill or single-word merge, with dirty set/clear controls).
- The FSM, counters and handshakes stay in the top module.

Test Plan:
All scenarios use a memory model with 3-cycle response latency and mem_req_ready=1, except where stated.
- Cold load 0x100: one AL request at addr 0x100 -> response fills the line, then is_output_valid with is_hit=0 and the memory word; miss_count=1.
- Repeat load 0x104 -> is_output_valid exactly 1 cycle after accept; is_hit=1; no mem_req_valid; hit_count=1.
- Store 0xDEADBEEF to 0x108 (hit), then load 0x1108 (same index, different tag):
  - Expect WB_REQ with addr 0x100, mem_wdata word2 = 0xDEADBEEF.
  - Then AL_REQ with addr 0x1100; load returns is_hit=0.
- Store miss to 0x2000 into a clean or invalid set -> no writeback; fill, merge; a later load of 0x2000 hits and returns the stored value.
- mem_req_ready held 0 for 5 cycles during AL_REQ -> mem_req_valid and mem_req_addr stay stable for all 5 cycles; is_ready stays 0; an is_input_valid pulse in that window is dropped.
- Reset asserted during AL_WAIT:
  - Next cycle: is_ready=1, mem_req_valid=0, counters 0.
  - A load of the previously cached address misses.

Source files
------------

// File: rtl/dcache_wb_responder_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, request encodings and address-split width helpers.
package dcache_wb_responder_pkg;

  localparam int DEF_NUM_SETS       = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Two low byte-address bits are dropped because the CPU only issues word accesses
  function automatic int tag_width(input int num_sets, input int words_per_line);
    return 32 - index_width(num_sets) - offset_width(words_per_line) - 2;
  endfunction

  function automatic int line_width(input int words_per_line);
    return 32 * words_per_line;
  endfunction

  localparam int OFFSET_W = offset_width(DEF_WORDS_PER_LINE);
  localparam int INDEX_W  = index_width(DEF_NUM_SETS);
  localparam int TAG_W    = tag_width(DEF_NUM_SETS, DEF_WORDS_PER_LINE);
  localparam int LINE_W   = line_width(DEF_WORDS_PER_LINE);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMPARE = 3'd1;
  localparam logic [2:0] ST_WB_REQ  = 3'd2;
  localparam logic [2:0] ST_WB_WAIT = 3'd3;
  localparam logic [2:0] ST_AL_REQ  = 3'd4;
  localparam logic [2:0] ST_AL_WAIT = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    COMPARE = ST_COMPARE,
    WB_REQ  = ST_WB_REQ,
    WB_WAIT = ST_WB_WAIT,
    AL_REQ  = ST_AL_REQ,
    AL_WAIT = ST_AL_WAIT
  } state_t;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

endpackage

// File: rtl/dcache_wb_responder_if.sv
// Block-granular backing-memory bus: valid/ready request channel plus a
// response-valid channel shared by fills and writeback acknowledges.
interface dcache_wb_responder_if #(
  parameter int LINE_W = dcache_wb_responder_pkg::LINE_W
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/dcache_wb_responder_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port and one
// synchronous write port doing either a full-line fill or a single-word merge.
module dcache_line_array
  import dcache_wb_responder_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [index_width(NUM_SETS)-1:0]              rd_index,
  output logic                                          rd_valid,
  output logic                                          rd_dirty,
  output logic [tag_width(NUM_SETS, WORDS_PER_LINE)-1:0] rd_tag,
  output logic [line_width(WORDS_PER_LINE)-1:0]         rd_line,
  input  logic                                          wr_fill,
  input  logic                                          wr_word_en,
  input  logic [index_width(NUM_SETS)-1:0]              wr_index,
  input  logic [tag_width(NUM_SETS, WORDS_PER_LINE)-1:0] wr_tag,
  input  logic [line_width(WORDS_PER_LINE)-1:0]         wr_line,
  input  logic [offset_width(WORDS_PER_LINE)-1:0]       wr_offset,
  input  logic [31:0]                                   wr_word
);

  localparam int TW = tag_width(NUM_SETS, WORDS_PER_LINE);
  localparam int LW = line_width(WORDS_PER_LINE);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [LW-1:0]       data_q [NUM_SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // A fill leaves the line clean; a word merge always marks it dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_fill) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (wr_word_en) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fill) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end else if (wr_word_en) begin
      data_q[wr_index][32*wr_offset +: 32] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_wb_responder.sv
// Direct-mapped write-back, write-allocate data cache sitting in the CPU MEM
// stage; misses write back a dirty victim, then allocate the requested line.
module dcache_wb_responder
  import dcache_wb_responder_pkg::*;
#(
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         is_input_valid,
  input  logic [31:0]                  addr,
  input  logic                         mem_rw,
  input  logic [31:0]                  din,
  output logic                         is_ready,
  output logic                         is_output_valid,
  output logic [31:0]                  dout,
  output logic                         is_hit,
  dcache_wb_responder_if.master        mem,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  localparam int OW = offset_width(WORDS_PER_LINE);
  localparam int IW = index_width(NUM_SETS);
  localparam int TW = tag_width(NUM_SETS, WORDS_PER_LINE);
  localparam int LW = line_width(WORDS_PER_LINE);

  state_t      state_q, state_d;
  logic [29:0] req_word_q;
  logic        req_rw_q;
  logic [31:0] req_din_q;
  logic        miss_q;
  logic [31:0] hit_count_q, miss_count_q;

  logic          accept, set_miss, count_hit, count_miss;
  logic          wr_fill, wr_word_en;
  logic          rd_valid, rd_dirty;
  logic [TW-1:0] rd_tag;
  logic [LW-1:0] rd_line;
  logic          lookup_hit;
  logic          req_valid, req_write;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          unused_addr_bits;

  logic [OW-1:0] req_offset;
  logic [IW-1:0] req_index;
  logic [TW-1:0] req_tag;

  assign unused_addr_bits = ^addr[1:0];
  assign req_offset = req_word_q[OW-1:0];
  assign req_index  = req_word_q[OW +: IW];
  assign req_tag    = req_word_q[29 -: TW];
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  dcache_line_array #(
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_lines (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (req_index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_fill    (wr_fill),
    .wr_word_en (wr_word_en),
    .wr_index   (req_index),
    .wr_tag     (req_tag),
    .wr_line    (mem.mem_rdata),
    .wr_offset  (req_offset),
    .wr_word    (req_din_q)
  );

  // Victim address/data come straight from the read port, which only the
  // fill or a hit-store can change, so they hold steady while stalled
  always_comb begin
    state_d         = state_q;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    dout            = '0;
    is_hit          = 1'b0;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    wr_fill         = 1'b0;
    wr_word_en      = 1'b0;
    accept          = 1'b0;
    set_miss        = 1'b0;
    count_hit       = 1'b0;
    count_miss      = 1'b0;
    case (state_q)
      IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          is_output_valid = 1'b1;
          is_hit          = !miss_q;
          count_hit       = !miss_q;
          count_miss      = miss_q;
          if (req_rw_q == RW_STORE) wr_word_en = 1'b1;
          else                      dout = rd_line[32*req_offset +: 32];
          state_d = IDLE;
        end else begin
          set_miss = 1'b1;
          state_d  = (rd_valid && rd_dirty) ? WB_REQ : AL_REQ;
        end
      end
      WB_REQ: begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = {rd_tag, req_index, {(OW + 2){1'b0}}};
        req_wdata = rd_line;
        if (mem.mem_req_ready) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem.mem_resp_valid) state_d = AL_REQ;
      end
      AL_REQ: begin
        req_valid = 1'b1;
        req_addr  = {req_tag, req_index, {(OW + 2){1'b0}}};
        if (mem.mem_req_ready) state_d = AL_WAIT;
      end
      AL_WAIT: begin
        if (mem.mem_resp_valid) begin
          wr_fill = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_word_q   <= '0;
      req_rw_q     <= RW_LOAD;
      req_din_q    <= '0;
      miss_q       <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_word_q <= addr[31:2];
        req_rw_q   <= mem_rw;
        req_din_q  <= din;
        miss_q     <= 1'b0;
      end else if (set_miss) begin
        miss_q <= 1'b1;
      end
      if (count_hit)  hit_count_q  <= hit_count_q + 32'd1;
      if (count_miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_write = req_write;
  assign mem.mem_req_addr  = req_addr;
  assign mem.mem_wdata     = req_wdata;
  assign hit_count         = hit_count_q;
  assign miss_count        = miss_count_q;

endmodule

// File: tb/tb_dcache_wb_responder.sv
// Directed bench for dcache_wb_responder against a 3-cycle-latency backing
// memory model; every expected value below is hand-derived.
module tb_dcache_wb_responder;
  import dcache_wb_responder_pkg::*;

  typedef struct {
    logic         write;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_input_valid;
  logic [31:0] addr;
  logic        mem_rw;
  logic [31:0] din;
  logic        is_ready;
  logic        is_output_valid;
  logic [31:0] dout;
  logic        is_hit;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;

  logic [31:0]  backing [logic [31:0]];
  req_t         req_log [$];
  bit           mem_busy;
  int           mem_cnt;
  logic [31:0]  mem_line_addr;
  logic [127:0] fill_line;

  dcache_wb_responder_if #(.LINE_W(128)) mem_bus ();

  dcache_wb_responder dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_rw          (mem_rw),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem             (mem_bus),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  // Untouched memory words read as their own address xor a fixed pattern
  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return a ^ 32'hCAFE0000;
  endfunction

  always @(posedge clk) begin
    if (!reset && mem_bus.mem_req_valid && mem_bus.mem_req_ready)
      req_log.push_back('{mem_bus.mem_req_write, mem_bus.mem_req_addr, mem_bus.mem_wdata});
  end

  always @(posedge clk) begin
    if (reset) begin
      mem_busy               <= 1'b0;
      mem_cnt                <= 0;
      mem_bus.mem_resp_valid <= 1'b0;
    end else begin
      mem_bus.mem_resp_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          for (int k = 0; k < 4; k++) fill_line[32*k +: 32] = read_word(mem_line_addr + 32'(4*k));
          mem_bus.mem_rdata      <= fill_line;
          mem_bus.mem_resp_valid <= 1'b1;
          mem_busy               <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        mem_busy      <= 1'b1;
        mem_cnt       <= 3;
        mem_line_addr <= mem_bus.mem_req_addr;
        if (mem_bus.mem_req_write)
          for (int k = 0; k < 4; k++)
            backing[mem_bus.mem_req_addr + 32'(4*k)] = mem_bus.mem_wdata[32*k +: 32];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request from IDLE and waits (bounded) for its completion pulse
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic rw,
                               input logic [31:0] d, output logic [31:0] rdata,
                               output logic hit, output int cycles);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(is_ready), 32'd1);
    is_input_valid = 1'b1;
    addr           = a;
    mem_rw         = rw;
    din            = d;
    @(negedge clk);
    is_input_valid = 1'b0;
    cycles = 1;
    while (!is_output_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_done"}, 32'(is_output_valid), 32'd1);
    rdata = dout;
    hit   = is_hit;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        hit;
  int          cyc;
  int          wait_cnt;
  bit          seen_ov;

  initial begin
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_rw         = RW_LOAD;
    din            = '0;
    mem_bus.mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    checkOutput("rst_is_ready", 32'(is_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(is_output_valid), 32'd0);
    checkOutput("rst_is_hit", 32'(is_hit), 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    checkOutput("rst_hit_count", hit_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);

    // Cold load: one fill of line 0x100
    req_log.delete();
    applyStimulus("cold", 32'h100, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("cold_dout", rd, 32'hCAFE0100);
    checkOutput("cold_hit", 32'(hit), 32'd0);
    checkOutput("cold_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) begin
      checkOutput("cold_req_write", 32'(req_log[0].write), 32'd0);
      checkOutput("cold_req_addr", req_log[0].addr, 32'h100);
    end
    checkOutput("cold_miss_count", miss_count, 32'd1);
    checkOutput("cold_hit_count", hit_count, 32'd0);

    // Repeat load in the same line
    req_log.delete();
    applyStimulus("rehit", 32'h104, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("rehit_latency", 32'(cyc), 32'd1);
    checkOutput("rehit_hit", 32'(hit), 32'd1);
    checkOutput("rehit_dout", rd, 32'hCAFE0104);
    checkOutput("rehit_nreq", 32'(req_log.size()), 32'd0);
    checkOutput("rehit_hit_count", hit_count, 32'd1);

    // Store hit dirties the line
    applyStimulus("sthit", 32'h108, RW_STORE, 32'hDEADBEEF, rd, hit, cyc);
    checkOutput("sthit_latency", 32'(cyc), 32'd1);
    checkOutput("sthit_hit", 32'(hit), 32'd1);
    checkOutput("sthit_hit_count", hit_count, 32'd2);

    // Conflict load evicts the dirty line
    req_log.delete();
    applyStimulus("evict", 32'h1108, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("evict_nreq", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      checkOutput("evict_wb_write", 32'(req_log[0].write), 32'd1);
      checkOutput("evict_wb_addr", req_log[0].addr, 32'h100);
      checkOutput("evict_wb_word2", req_log[0].wdata[95:64], 32'hDEADBEEF);
      checkOutput("evict_wb_word0", req_log[0].wdata[31:0], 32'hCAFE0100);
      checkOutput("evict_al_write", 32'(req_log[1].write), 32'd0);
      checkOutput("evict_al_addr", req_log[1].addr, 32'h1100);
    end
    checkOutput("evict_hit", 32'(hit), 32'd0);
    checkOutput("evict_dout", rd, 32'hCAFE1108);
    checkOutput("evict_miss_count", miss_count, 32'd2);

    // Written-back data comes back from memory; clean victim needs no writeback
    req_log.delete();
    applyStimulus("refetch", 32'h108, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("refetch_nreq", 32'(req_log.size()), 32'd1);
    checkOutput("refetch_dout", rd, 32'hDEADBEEF);
    checkOutput("refetch_hit", 32'(hit), 32'd0);
    checkOutput("refetch_miss_count", miss_count, 32'd3);

    // Store miss into a clean set: fill then merge
    req_log.delete();
    applyStimulus("stmiss", 32'h2000, RW_STORE, 32'h12345678, rd, hit, cyc);
    checkOutput("stmiss_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) begin
      checkOutput("stmiss_req_write", 32'(req_log[0].write), 32'd0);
      checkOutput("stmiss_req_addr", req_log[0].addr, 32'h2000);
    end
    checkOutput("stmiss_hit", 32'(hit), 32'd0);
    checkOutput("stmiss_miss_count", miss_count, 32'd4);
    applyStimulus("stload", 32'h2000, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("stload_latency", 32'(cyc), 32'd1);
    checkOutput("stload_hit", 32'(hit), 32'd1);
    checkOutput("stload_dout", rd, 32'h12345678);
    checkOutput("stload_hit_count", hit_count, 32'd3);

    // Backpressure on the allocate request; a request pulse in the window is dropped
    req_log.delete();
    mem_bus.mem_req_ready = 1'b0;
    @(negedge clk);
    is_input_valid = 1'b1;
    addr           = 32'h340;
    mem_rw         = RW_LOAD;
    @(negedge clk);
    is_input_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_valid_%0d", i), 32'(mem_bus.mem_req_valid), 32'd1);
      checkOutput($sformatf("stall_addr_%0d", i), mem_bus.mem_req_addr, 32'h340);
      checkOutput($sformatf("stall_write_%0d", i), 32'(mem_bus.mem_req_write), 32'd0);
      checkOutput($sformatf("stall_ready_%0d", i), 32'(is_ready), 32'd0);
      if (i == 2) begin
        is_input_valid = 1'b1;
        addr           = 32'h500;
      end else begin
        is_input_valid = 1'b0;
      end
      @(negedge clk);
    end
    mem_bus.mem_req_ready = 1'b1;
    wait_cnt = 0;
    while (!is_output_valid && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("stall_done", 32'(is_output_valid), 32'd1);
    checkOutput("stall_dout", dout, 32'hCAFE0340);
    checkOutput("stall_hit", 32'(is_hit), 32'd0);
    seen_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_ov |= is_output_valid;
    end
    checkOutput("stall_no_extra_out", 32'(seen_ov), 32'd0);
    checkOutput("stall_nreq", 32'(req_log.size()), 32'd1);
    checkOutput("stall_miss_count", miss_count, 32'd5);

    // Reset while waiting for a fill aborts everything
    req_log.delete();
    @(negedge clk);
    is_input_valid = 1'b1;
    addr           = 32'h380;
    mem_rw         = RW_LOAD;
    @(negedge clk);
    is_input_valid = 1'b0;
    wait_cnt = 0;
    while (req_log.size() == 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("rstmid_al_issued", 32'(req_log.size()), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstmid_is_ready", 32'(is_ready), 32'd1);
    checkOutput("rstmid_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    checkOutput("rstmid_hit_count", hit_count, 32'd0);
    checkOutput("rstmid_miss_count", miss_count, 32'd0);
    seen_ov = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_ov |= is_output_valid;
    end
    checkOutput("rstmid_no_late_out", 32'(seen_ov), 32'd0);
    req_log.delete();
    applyStimulus("postrst", 32'h340, RW_LOAD, 32'h0, rd, hit, cyc);
    checkOutput("postrst_hit", 32'(hit), 32'd0);
    checkOutput("postrst_dout", rd, 32'hCAFE0340);
    checkOutput("postrst_nreq", 32'(req_log.size()), 32'd1);
    checkOutput("postrst_miss_count", miss_count, 32'd1);
    checkOutput("postrst_hit_count", hit_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
